// File: rtl/mod_pkg.sv
// Shared constants and types for the modular-arithmetic blocks:
// default datapath width, iteration count and controller states.
package mod_pkg;

  localparam int MOD_WIDTH = 19;

  // The operand limit n < 2^(width-2) leaves two bits of headroom.
  // That headroom sets the number of shift-add steps.
  function automatic int mod_iter(input int width);
    return width - 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mod.sv
// Combinational restoring divider stage: r = a mod m, q = a / m.
// When m is zero the result is q = all ones and r = a.
module mod
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    logic [WIDTH:0] rem;
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    q   = '0;
    rem = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], a[i]};
      if (rem >= {1'b0, m}) begin
        rem  = rem - {1'b0, m};
        q[i] = 1'b1;
      end
    end
    r = rem[WIDTH-1:0];
  end

endmodule

// File: rtl/modmul_seq.sv
// Sequential modular multiplier computing (x*y) mod n.
// It processes one multiplier bit per cycle, MSB first, with a valid/ready handshake on each side.
module modmul_seq
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int ITER  = mod_iter(WIDTH);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, n_q, n_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] red_op, rem, quo_unused;
  logic             legal;

  // The upper two bits of n must be zero, so 2*acc + x stays below 3n and fits in WIDTH bits.
  assign legal = (n != '0) && (n[WIDTH-1:WIDTH-2] == 2'b00) && (x < n) && (y < n);

  assign red_op = {acc_q[WIDTH-2:0], 1'b0} + (y_q[cnt_q] ? x_q : '0);

  mod #(
    .WIDTH(WIDTH)
  ) u_mod (
    .a(red_op),
    .m(n_q),
    .q(quo_unused),
    .r(rem)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    n_d         = n_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (legal) begin
            x_d     = x;
            y_d     = y;
            n_d     = n;
            acc_d   = '0;
            cnt_d   = CNT_W'(ITER - 1);
            state_d = RUN;
          end else begin
            out_valid_d = 1'b1;
            err_d       = 1'b1;
            result_d    = '0;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        acc_d = rem;
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          result_d    = rem;
          err_d       = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          result_d    = '0;
          err_d       = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments.
  // Every flop then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_modmul_seq.sv
// Scoreboard bench for modmul_seq: the expected result, error flag and
// latency are queued when operands are driven and compared when out_valid rises.
module tb_modmul_seq;

  localparam int W    = 19;
  localparam int ITER = W - 2;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0, y = '0, n = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         err;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  modmul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .n(n), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                 input logic [W-1:0] ni);
    exp_t e;
    longint unsigned prod;
    if (ni != 0 && 32'(ni) < (32'd1 << (W - 2)) && xi < ni && yi < ni) begin
      prod  = longint'(xi) * longint'(yi);
      e.res = W'(prod % longint'(ni));
      e.err = 1'b0;
      e.lat = ITER;
    end else begin
      e.res = '0;
      e.err = 1'b1;
      e.lat = 0;
    end
    return e;
  endfunction

  // Drive one transaction, wait for its result, optionally apply backpressure, then release it.
  task automatic do_txn(input string name, input logic [W-1:0] xi, input logic [W-1:0] yi,
                        input logic [W-1:0] ni, input int hold);
    exp_t e;
    int   lat;
    logic leak;
    logic [W-1:0] held_res;
    logic held_err;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    x = xi; y = yi; n = ni; in_valid = 1'b1;
    sb.push_back(model(xi, yi, ni));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat  = 0;
    leak = 1'b0;
    while (!out_valid && lat < 100) begin
      if (result != '0 || err != 1'b0) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({name, "_latency"}, 32'(lat), 32'(e.lat));
    check({name, "_quiet"}, 32'(leak), 32'd0);
    check({name, "_result"}, 32'(result), 32'(e.res));
    check({name, "_err"}, 32'(err), 32'(e.err));
    if (hold > 0) begin
      held_res = result;
      held_err = err;
      x = 19'd3; y = 19'd4; n = 19'd5; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (i == hold - 1) begin
          check({name, "_bp_in_ready"}, 32'(in_ready), 32'd0);
          check({name, "_bp_valid"}, 32'(out_valid), 32'd1);
          check({name, "_bp_result"}, 32'(result), 32'(held_res));
          check({name, "_bp_err"}, 32'(err), 32'(held_err));
        end
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_release_valid"}, 32'(out_valid), 32'd0);
    check({name, "_release_ready"}, 32'(in_ready), 32'd1);
    check({name, "_release_result"}, 32'(result), 32'd0);
  endtask

  initial begin
    logic quiet;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    do_txn("basic", 19'd5, 19'd7, 19'd11, 0);
    do_txn("max", 19'd131070, 19'd131070, 19'd131071, 0);
    do_txn("zero_x", 19'd0, 19'd9, 19'd13, 0);
    do_txn("n_one", 19'd0, 19'd0, 19'd1, 0);
    do_txn("n_zero", 19'd1, 19'd2, 19'd0, 0);
    do_txn("n_big", 19'd1, 19'd2, 19'd131072, 0);
    do_txn("x_ge_n", 19'd12, 19'd3, 19'd11, 0);
    do_txn("y_eq_n", 19'd3, 19'd11, 19'd11, 0);
    do_txn("backpressure", 19'd1234, 19'd5678, 19'd99991, 10);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] rn, rx, ry;
      rn = W'($urandom_range(131071, 2));
      rx = W'($urandom_range(32'(rn) - 1, 0));
      ry = W'($urandom_range(32'(rn) - 1, 0));
      do_txn($sformatf("rand%0d", i), rx, ry, rn, 0);
    end

    // Abort a transaction with reset part-way through RUN.
    @(negedge clk);
    x = 19'd100; y = 19'd200; n = 19'd1000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check("midrst_no_pulse", 32'(quiet), 32'd1);
    do_txn("post_rst", 19'd3, 19'd4, 19'd5, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
